alu_result_latch: RTL and testbench

Registered output stage directly downstream of the 4-bit ALU. It captures the combinational ALU result and its Ze/N/C/V flags on a debounced push-button step. It keeps a 4-entry circular history of captured results and drives the value presented to the seven-segment decoder. `acc_out` is returned upstream so the top level can route it to the ALU A operand for accumulate-style chaining.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 97 +++++++++
 rtl/alu_result_latch.sv | 67 ++++++
 tb/tb_alu_result_latch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result latch slice: FSM encoding, flag bit
// positions, history depth and the history read-index helper.
// Pure declarations; no latency or flow control of its own.
package alu_pkg;

  // Debounce FSM state encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_CAPTURE  = 2'd2;
  localparam logic [1:0] ST_WAIT_REL = 2'd3;

  // Bit positions inside the {Ze, N, C, V} flag nibble
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // History ring depth; pointer arithmetic relies on this being 4 (2-bit wrap)
  localparam int HIST_DEPTH = 4;

  // Index of the entry hist_sel steps back from the newest capture.
  // wp points at the next slot to write, so the newest entry is wp-1.
  function automatic logic [1:0] hist_rd_idx(input logic [1:0] wp,
                                             input logic [1:0] sel);
    return wp - 2'd1 - sel;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes and debounces the raw step button into a single capture pulse.
// Latency: pulse asserted DEBOUNCE_CYCLES+3 cycles after a clean raw rising edge.
// No backpressure: one pulse per accepted press; release must settle before re-arm.
module btn_debounce
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic step_btn,
  output logic capture_pulse,
  output logic busy
);

  localparam logic [15:0] DB_LIMIT   = 16'(DEBOUNCE_CYCLES);
  localparam logic [15:0] DB_REL_END = 16'(DEBOUNCE_CYCLES - 1);

  logic        sync_1;
  logic        btn_s;
  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;

  // Two-flop synchronizer for the asynchronous button input
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      sync_1 <= step_btn;
      btn_s  <= sync_1;
    end
  end

  // Next-state and counter logic for press/release debouncing
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        cnt_nxt = 16'd0;
        if (btn_s) begin
          state_nxt = ST_ARMED;
          cnt_nxt   = 16'd1;
        end
      end
      ST_ARMED: begin
        if (!btn_s) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 16'd0;
        end else if (cnt == DB_LIMIT) begin
          state_nxt = ST_CAPTURE;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ST_CAPTURE: begin
        state_nxt = ST_WAIT_REL;
        cnt_nxt   = 16'd0;
      end
      ST_WAIT_REL: begin
        // Any high sample during release restarts the settle count
        if (btn_s) begin
          cnt_nxt = 16'd0;
        end else if (cnt == DB_REL_END) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 16'd0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 16'd0;
      end
    endcase
  end

  // State, counter and registered busy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 16'd0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt != ST_IDLE);
    end
  end

  // Capture strobe is a straight decode of the state register
  assign capture_pulse = (state == ST_CAPTURE);

endmodule

// File: rtl/alu_result_latch.sv
// Latches ALU result/flags on a debounced step and keeps a 4-deep result history.
// Latency: outputs update DEBOUNCE_CYCLES+4 cycles after a clean button edge.
// No backpressure: ALU inputs are sampled only in the capture cycle, ignored otherwise.
module alu_result_latch
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_btn,
  input  logic [3:0] alu_y,
  input  logic [3:0] alu_flags,
  input  logic [1:0] hist_sel,
  output logic [3:0] acc_out,
  output logic [3:0] flags_out,
  output logic [3:0] disp_out,
  output logic [7:0] step_count,
  output logic       busy
);

  logic       capture_pulse;
  logic [3:0] hist [HIST_DEPTH];
  logic [1:0] wp;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk           (clk),
    .reset         (reset),
    .step_btn      (step_btn),
    .capture_pulse (capture_pulse),
    .busy          (busy)
  );

  // Accumulator, flags and capture counter update once per accepted press
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_out    <= 4'd0;
      flags_out  <= 4'd0;
      step_count <= 8'd0;
    end else if (capture_pulse) begin
      acc_out    <= alu_y;
      flags_out  <= alu_flags;
      step_count <= step_count + 8'd1;
    end
  end

  // History ring: write at wp, then advance; 2-bit wp wraps mod 4 naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist[i] <= 4'd0;
      end
      wp <= 2'd0;
    end else if (capture_pulse) begin
      hist[wp] <= alu_y;
      wp       <= wp + 2'd1;
    end
  end

  // Display readout: hist_sel steps back from the newest capture
  always_comb begin
    disp_out = hist[hist_rd_idx(wp, hist_sel)];
  end

endmodule

// File: tb/tb_alu_result_latch.sv
module tb_alu_result_latch;

  logic       clk;
  logic       reset;
  logic       step_btn;
  logic [3:0] alu_y;
  logic [3:0] alu_flags;
  logic [1:0] hist_sel;
  logic [3:0] acc_out;
  logic [3:0] flags_out;
  logic [3:0] disp_out;
  logic [7:0] step_count;
  logic       busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] model_cnt;

  typedef struct {
    logic [3:0] y;
    logic [3:0] f;
    logic [3:0] exp_acc;
    logic [3:0] exp_flags;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t       vecs [5];
  logic [3:0] hist_exp [4];

  alu_result_latch #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .step_btn   (step_btn),
    .alu_y      (alu_y),
    .alu_flags  (alu_flags),
    .hist_sel   (hist_sel),
    .acc_out    (acc_out),
    .flags_out  (flags_out),
    .disp_out   (disp_out),
    .step_count (step_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    step_btn = 1'b0;
    tick(2);
    reset     = 1'b0;
    model_cnt = 8'd0;
  endtask

  // Full press: wait (bounded) for the capture, hold briefly, release and settle
  task automatic press(input logic [3:0] y, input logic [3:0] f);
    int n;
    alu_y     = y;
    alu_flags = f;
    step_btn  = 1'b1;
    model_cnt = model_cnt + 8'd1;
    n = 0;
    while (step_count !== model_cnt && n < 30) begin
      tick(1);
      n++;
    end
    check("press_capture", step_count, model_cnt);
    tick(2);
    step_btn = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 30) begin
      tick(1);
      n++;
    end
    check("press_release_idle", busy, 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{y: 4'h1, f: 4'b1000, exp_acc: 4'h1, exp_flags: 4'b1000, exp_cnt: 8'd1};
    vecs[1] = '{y: 4'h2, f: 4'b0100, exp_acc: 4'h2, exp_flags: 4'b0100, exp_cnt: 8'd2};
    vecs[2] = '{y: 4'h3, f: 4'b0010, exp_acc: 4'h3, exp_flags: 4'b0010, exp_cnt: 8'd3};
    vecs[3] = '{y: 4'h4, f: 4'b0001, exp_acc: 4'h4, exp_flags: 4'b0001, exp_cnt: 8'd4};
    vecs[4] = '{y: 4'h5, f: 4'b1111, exp_acc: 4'h5, exp_flags: 4'b1111, exp_cnt: 8'd5};
    hist_exp[0] = 4'h5;
    hist_exp[1] = 4'h4;
    hist_exp[2] = 4'h3;
    hist_exp[3] = 4'h2;

    reset     = 1'b1;
    step_btn  = 1'b0;
    alu_y     = 4'hA;
    alu_flags = 4'b1010;
    hist_sel  = 2'd0;
    model_cnt = 8'd0;

    // Reset state
    do_reset();
    check("rst_acc", acc_out, 0);
    check("rst_flags", flags_out, 0);
    check("rst_count", step_count, 0);
    check("rst_busy", busy, 0);
    for (int s = 0; s < 4; s++) begin
      hist_sel = 2'(s);
      #1;
      check("rst_disp", disp_out, 0);
    end
    hist_sel = 2'd0;

    // Clean press: capture lands exactly 8 edges after the raw edge
    alu_y     = 4'h9;
    alu_flags = 4'b0110;
    step_btn  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (k == 2) check("clean_busy_low", busy, 0);
      if (k == 3) check("clean_busy_high", busy, 1);
      if (k == 7) check("clean_no_early", step_count, 0);
    end
    check("clean_count", step_count, 1);
    check("clean_acc", acc_out, 4'h9);
    check("clean_flags", flags_out, 4'b0110);
    check("clean_disp0", disp_out, 4'h9);
    for (int s = 1; s < 4; s++) begin
      hist_sel = 2'(s);
      #1;
      check("clean_unwritten", disp_out, 0);
    end
    hist_sel = 2'd0;
    tick(12);
    check("clean_no_repeat", step_count, 1);
    step_btn = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 30) begin
      tick(1);
      n++;
    end
    check("clean_release", busy, 0);
    check("clean_final_count", step_count, 1);

    // Bounce: 2-cycle chatter never arms long enough to capture
    do_reset();
    alu_y     = 4'hC;
    alu_flags = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      step_btn = ((i / 2) % 2 == 0);
      tick(1);
    end
    check("bounce_no_capture", step_count, 0);
    step_btn = 1'b1;
    n = 0;
    while (step_count !== 8'd1 && n < 30) begin
      tick(1);
      n++;
    end
    check("bounce_capture", step_count, 1);
    check("bounce_acc", acc_out, 4'hC);
    tick(3);
    alu_y = 4'h3;  // ALU changes while waiting for release must not be latched
    for (int i = 0; i < 12; i++) begin
      step_btn = ((i / 2) % 2 == 1);
      tick(1);
    end
    step_btn = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 30) begin
      tick(1);
      n++;
    end
    check("bounce_release_idle", busy, 0);
    tick(10);
    check("bounce_no_second", step_count, 1);
    check("bounce_acc_held", acc_out, 4'hC);

    // History: table-driven captures
    do_reset();
    for (int i = 0; i < 5; i++) begin
      press(vecs[i].y, vecs[i].f);
      check("hist_acc", acc_out, vecs[i].exp_acc);
      check("hist_flags", flags_out, vecs[i].exp_flags);
      check("hist_count", step_count, vecs[i].exp_cnt);
    end
    for (int s = 0; s < 4; s++) begin
      hist_sel = 2'(s);
      #1;
      check("hist_disp", disp_out, hist_exp[s]);
    end
    hist_sel = 2'd0;

    // Wrap: 256 captures bring the counter back to 0
    do_reset();
    for (int i = 0; i < 256; i++) begin
      press(4'(i), 4'(i + 1));
    end
    check("wrap_count", step_count, 0);
    check("wrap_acc", acc_out, 4'hF);
    check("wrap_flags", flags_out, 4'h0);
    hist_sel = 2'd0;
    #1;
    check("wrap_disp0", disp_out, 4'hF);
    hist_sel = 2'd1;
    #1;
    check("wrap_disp1", disp_out, 4'hE);
    hist_sel = 2'd3;
    #1;
    check("wrap_disp3", disp_out, 4'hC);
    hist_sel = 2'd0;

    // Reset during ARMED with button held: discarded, then one fresh capture
    do_reset();
    alu_y     = 4'h7;
    alu_flags = 4'b0101;
    step_btn  = 1'b1;
    tick(4);
    check("midarm_busy", busy, 1);
    reset = 1'b1;
    tick(2);
    check("midarm_rst_count", step_count, 0);
    check("midarm_rst_acc", acc_out, 0);
    check("midarm_rst_busy", busy, 0);
    reset = 1'b0;
    tick(7);
    check("midarm_no_early", step_count, 0);
    tick(1);
    check("midarm_count", step_count, 1);
    check("midarm_acc", acc_out, 4'h7);
    tick(10);
    step_btn = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 30) begin
      tick(1);
      n++;
    end
    check("midarm_release", busy, 0);
    check("midarm_single", step_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
